// File: rtl/npc_pkg.sv
// Shared definitions for the fetch-PC generator.
//   XLEN_DEFAULT : default data/address width
//   NPC_*        : resolved next-PC op encodings carried from EX (2'b11 behaves as PC4)
//   btb_entry_t  : one BTB line {valid, tag, target}; the tag field is full width and
//                  holds PC >> (log2(depth) + 2), so its upper bits are constant zero.
package npc_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_RA  = 2'b01;
  localparam logic [1:0] NPC_IMM = 2'b10;

  typedef struct packed {
    logic                    valid;
    logic [XLEN_DEFAULT-1:0] tag;
    logic [XLEN_DEFAULT-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/pc_gen_if.sv
// EX-stage resolution bus between the execute stage and the fetch-PC generator.
//   master : EX side, drives the resolved instruction, receives the redirect
//   slave  : pc_gen side, consumes the resolved instruction, drives the redirect
interface pc_gen_if #(
  parameter int unsigned XLEN = npc_pkg::XLEN_DEFAULT
);
  logic            ex_valid_i;
  logic [1:0]      ex_op_i;
  logic [XLEN-1:0] ex_pc_i;
  logic [XLEN-1:0] ex_imm_i;
  logic [XLEN-1:0] ex_ra_i;
  logic            ex_pred_taken_i;
  logic [XLEN-1:0] ex_pred_target_i;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport master (
    output ex_valid_i, ex_op_i, ex_pc_i, ex_imm_i, ex_ra_i, ex_pred_taken_i, ex_pred_target_i,
    input  redirect_o, redirect_pc_o
  );

  modport slave (
    input  ex_valid_i, ex_op_i, ex_pc_i, ex_imm_i, ex_ra_i, ex_pred_taken_i, ex_pred_target_i,
    output redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer.
//   clk_i, rst_n_i        : clock, synchronous active-low clear of all valid bits
//   rd_pc_i               : combinational lookup address
//   rd_hit_o, rd_target_o : lookup result (target is raw entry data, qualify with hit)
//   wr_en_i               : write {1, tag, wr_target_i} at index of wr_pc_i
//   inv_en_i              : clear valid at index of wr_pc_i (wr_en_i has priority)
// A write and a lookup of the same index in one cycle return the old entry.
module npc_btb
  import npc_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [XLEN_DEFAULT-1:0] rd_pc_i,
  output logic                    rd_hit_o,
  output logic [XLEN_DEFAULT-1:0] rd_target_o,
  input  logic                    wr_en_i,
  input  logic                    inv_en_i,
  input  logic [XLEN_DEFAULT-1:0] wr_pc_i,
  input  logic [XLEN_DEFAULT-1:0] wr_target_i
);

  localparam int unsigned Idx = $clog2(Depth);

  btb_entry_t              mem_q [Depth];
  btb_entry_t              rd_entry;
  logic [Idx-1:0]          rd_idx;
  logic [Idx-1:0]          wr_idx;
  logic [XLEN_DEFAULT-1:0] rd_tag;
  logic [XLEN_DEFAULT-1:0] wr_tag;

  assign rd_idx = rd_pc_i[Idx+1:2];
  assign wr_idx = wr_pc_i[Idx+1:2];
  assign rd_tag = rd_pc_i >> (Idx + 2);
  assign wr_tag = wr_pc_i >> (Idx + 2);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i].valid <= 1'b0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target_i};
    end else if (inv_en_i) begin
      mem_q[wr_idx].valid <= 1'b0;
    end
  end

  always_comb begin
    rd_entry    = mem_q[rd_idx];
    rd_hit_o    = rd_entry.valid && (rd_entry.tag == rd_tag);
    rd_target_o = rd_entry.target;
  end

endmodule

// File: rtl/pc_gen.sv
// Registered fetch-PC generator with optional BTB-based taken prediction.
//   clk_i, rst_n_i   : clock, synchronous active-low reset
//   stall_i          : hold the fetch PC
//   pc_o, pc4_o      : current fetch PC and fetch PC + 4
//   pred_taken_o     : BTB hit for pc_o
//   pred_target_o    : predicted target for pc_o (0 without a hit)
//   ex_if            : resolved control flow from EX in, redirect/redirect PC out
//   mispredict_cnt_o : saturating count of redirects
// Build option: define NPC_BTB_EN to include the BTB; otherwise prediction is
// always not-taken and every taken transfer redirects.
module pc_gen
  import npc_pkg::*;
#(
  parameter int unsigned    XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned    BTB_DEPTH = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  pc_gen_if.slave         ex_if,
  output logic [31:0]     mispredict_cnt_o
);

  if (BTB_DEPTH < 2 || (BTB_DEPTH & (BTB_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("BTB_DEPTH must be a power of two and at least 2");
  end

  logic [XLEN-1:0] pc_q;
  logic [31:0]     cnt_q;
  logic [XLEN-1:0] actual_target;
  logic            actual_taken;
  logic            mispredict;

  assign pc_o             = pc_q;
  assign pc4_o            = pc_q + XLEN'(4);
  assign mispredict_cnt_o = cnt_q;

  always_comb begin
    unique case (ex_if.ex_op_i)
      NPC_IMM: actual_target = ex_if.ex_pc_i + ex_if.ex_imm_i;
      NPC_RA:  actual_target = (ex_if.ex_ra_i + ex_if.ex_imm_i) & ~XLEN'(1);
      default: actual_target = ex_if.ex_pc_i + XLEN'(4);
    endcase
  end

  assign actual_taken = (ex_if.ex_op_i == NPC_IMM) || (ex_if.ex_op_i == NPC_RA);
  assign mispredict   = (actual_taken != ex_if.ex_pred_taken_i) ||
                        (actual_taken && (actual_target != ex_if.ex_pred_target_i));

  assign ex_if.redirect_o    = ex_if.ex_valid_i & mispredict & rst_n_i;
  assign ex_if.redirect_pc_o = ex_if.redirect_o ? actual_target : '0;

`ifdef NPC_BTB_EN
  if (XLEN != XLEN_DEFAULT) begin : g_bad_xlen
    $error("BTB entries are sized for XLEN_DEFAULT");
  end

  logic            btb_hit;
  logic [XLEN-1:0] btb_target;

  // Training ignores stall_i: EX resolution is independent of fetch hold.
  npc_btb #(
    .Depth (BTB_DEPTH)
  ) u_btb (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .rd_pc_i     (pc_q),
    .rd_hit_o    (btb_hit),
    .rd_target_o (btb_target),
    .wr_en_i     (ex_if.ex_valid_i & actual_taken),
    .inv_en_i    (ex_if.ex_valid_i & ~actual_taken & ex_if.ex_pred_taken_i),
    .wr_pc_i     (ex_if.ex_pc_i),
    .wr_target_i (actual_target)
  );

  assign pred_taken_o  = rst_n_i & btb_hit;
  assign pred_target_o = pred_taken_o ? btb_target : '0;
`else
  assign pred_taken_o  = 1'b0;
  assign pred_target_o = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_q <= RESET_PC;
    end else if (ex_if.redirect_o) begin
      pc_q <= ex_if.redirect_pc_o;
    end else if (stall_i) begin
      pc_q <= pc_q;
    end else if (pred_taken_o) begin
      pc_q <= pred_target_o;
    end else begin
      pc_q <= pc4_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (ex_if.redirect_o && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Registered fetch-PC generator for the pipelined RV32 core. Replaces the single-cycle combinational next-PC selector. It holds the fetch PC and predicts taken control flow through a direct-mapped branch target buffer (BTB). It accepts resolved control flow from EX, raises a redirect on misprediction and trains the BTB.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, fetch PC after reset
- BTB_DEPTH, 16, BTB entries; power of two, ≥2
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  reset, synchronous, active-low
- stall_i  input  1  hold fetch PC
- pc_o  output  XLEN  current fetch PC (registered)
- pc4_o  output  XLEN  pc_o + 4
- pred_taken_o  output  1  BTB hit for pc_o
- pred_target_o  output  XLEN  predicted target for pc_o (0 when no hit)
- ex_valid_i  input  1  EX holds a resolved instruction this cycle
- ex_op_i  input  2  resolved next-PC op: 00 PC4, 01 RA (jalr), 10 IMM (branch taken/jal), 11 treated as PC4
- ex_pc_i, ex_imm_i, ex_ra_i  input  XLEN  instruction PC, immediate, rs1 value
- ex_pred_taken_i  input  1  prediction carried with the instruction
- ex_pred_target_i  input  XLEN  predicted target carried with the instruction
- redirect_o  output  1  mispredict; flush IF/ID (combinational)
- redirect_pc_o  output  XLEN  correct next PC when redirect_o is high
- mispredict_cnt_o  output  32  saturating mispredict count

## Operation
- Actual target:
  - IMM: ex_pc_i + ex_imm_i
  - RA: (ex_ra_i + ex_imm_i) with bit 0 cleared
  - PC4: ex_pc_i + 4
- actual_taken = (op is IMM or RA).
- Mispredict, evaluated only when ex_valid_i is high:
  - actual_taken ≠ ex_pred_taken_i, or
  - actual_taken and target ≠ ex_pred_target_i.
- redirect_o = ex_valid_i & mispredict & rst_n_i.
- redirect_pc_o = actual target when redirect_o is high, else 0.
- Next PC priority: reset → RESET_PC; redirect → redirect_pc_o; stall_i → hold; pred_taken_o → pred_target_o; otherwise pc_o + 4.
- BTB entry: valid, tag = PC[XLEN-1:IDX+2], target; index = PC[IDX+1:2], IDX = log2(BTB_DEPTH). Lookup on pc_o is combinational.
- BTB training on the clock edge when ex_valid_i is high:
  - actual_taken: write {1, tag, target} at index of ex_pc_i.
  - op PC4 with ex_pred_taken_i: clear valid at that index.
  - Training is independent of stall_i.
- A same-cycle lookup and write to the same index returns the old entry; the new entry is visible next cycle.
- mispredict_cnt_o increments on every redirect_o and saturates at 32'hFFFF_FFFF.
- All adders wrap modulo 2^XLEN.

## Timing
- Reset (rst_n_i low at an edge):
  - pc_o = RESET_PC, mispredict_cnt_o = 0, all BTB valid bits = 0.
  - While rst_n_i is low: pred_taken_o = 0, pred_target_o = 0, redirect_o = 0.
  - Reset mid-redirect: reset wins and the pending redirect is dropped.
- Redirect: redirect_o asserts in the same cycle as ex_valid_i. pc_o equals redirect_pc_o after the next edge, which gives a one-cycle latency.
- Redirect and stall_i together: redirect wins.
- Predicted-taken: pc_o equals pred_target_o after one edge, with no bubble.
- Stall: pc_o holds for exactly the number of cycles stall_i is high.

## Configuration
- NPC_BTB_EN defined: BTB is present as described.
- NPC_BTB_EN undefined:
  - No BTB storage; pred_taken_o = 0 and pred_target_o = 0 always.
  - Next PC is pc_o + 4 unless a redirect or stall applies.
  - Every taken control transfer produces a redirect.
  - Training inputs are ignored apart from mispredict detection.

## Structure
- Package npc_pkg holds:
  - NPC_PC4 = 2'b00, NPC_RA = 2'b01, NPC_IMM = 2'b10
  - default XLEN
  - BTB entry struct typedef (valid, tag, target)
- One sub-module, npc_btb:
  - contains the storage, the combinational lookup port and the synchronous write/invalidate port
  - has its own synchronous active-low clear of valid bits
  - is instantiated only under NPC_BTB_EN.

## Test plan
- Reset, then rst_n_i high with no stall → pc_o sequence 0x0, 0x4, 0x8; pred_taken_o = 0; mispredict_cnt_o = 0.
- stall_i high for 3 cycles at pc_o = 0x8 → pc_o stays 0x8 for 3 cycles, then 0xC.
- Branch mispredict and training:
  - Stimulus: ex_valid_i, op IMM, ex_pc 0x10, imm 0x20, pred_taken 0.
  - Response: redirect_o = 1 and redirect_pc_o = 0x30 in the same cycle; next pc_o = 0x30; mispredict_cnt_o = 1.
  - On a later fetch of 0x10: pred_taken_o = 1, pred_target_o = 0x30, and the following pc_o = 0x30.
- jalr with op RA, ra 0x1001, imm 0x4 → redirect_pc_o = 0x1004 (bit 0 cleared).
- Prediction checks on ex_pc 0x10:
  - Correct prediction (op IMM, pred_taken 1, pred_target 0x30) → redirect_o = 0.
  - False hit (op PC4, pred_taken 1) → redirect to 0x14 and the BTB entry is invalidated.
- Priority and wrap:
  - Redirect to 0xFFFF_FFFC in the same cycle as stall_i → pc_o = 0xFFFF_FFFC.
  - Then no stall → next pc_o = 0x0.
  - With NPC_BTB_EN undefined → pred_taken_o stays 0 throughout.
